// File: rtl/ram_sp_be_192x512_arb_if.sv
// Requester and RAM-side bus of the single-port bit-enable RAM arbiter.
interface ram_sp_be_192x512_arb_if #(
  parameter int unsigned ADR_WD = 8,
  parameter int unsigned DAT_WD = 512
);
  logic              w_req_i;
  logic [ADR_WD-1:0] w_adr_i;
  logic [DAT_WD-1:0] w_msk_i;
  logic [DAT_WD-1:0] w_dat_i;
  logic              w_ack_o;

  logic              r0_req_i;
  logic [ADR_WD-1:0] r0_adr_i;
  logic              r0_ack_o;
  logic              r0_vld_o;
  logic [DAT_WD-1:0] r0_dat_o;

  logic              r1_req_i;
  logic [ADR_WD-1:0] r1_adr_i;
  logic              r1_ack_o;
  logic              r1_vld_o;
  logic [DAT_WD-1:0] r1_dat_o;

  logic [ADR_WD-1:0] ram_adr_o;
  logic [DAT_WD-1:0] ram_wr_ena_o;
  logic [DAT_WD-1:0] ram_wr_dat_o;
  logic              ram_rd_ena_o;
  logic [DAT_WD-1:0] ram_rd_dat_i;

  // Arbiter side
  modport slave (
    input  w_req_i, w_adr_i, w_msk_i, w_dat_i,
    output w_ack_o,
    input  r0_req_i, r0_adr_i,
    output r0_ack_o, r0_vld_o, r0_dat_o,
    input  r1_req_i, r1_adr_i,
    output r1_ack_o, r1_vld_o, r1_dat_o,
    output ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o,
    input  ram_rd_dat_i
  );

  // Requester / RAM-macro side
  modport master (
    output w_req_i, w_adr_i, w_msk_i, w_dat_i,
    input  w_ack_o,
    output r0_req_i, r0_adr_i,
    input  r0_ack_o, r0_vld_o, r0_dat_o,
    output r1_req_i, r1_adr_i,
    input  r1_ack_o, r1_vld_o, r1_dat_o,
    input  ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o,
    output ram_rd_dat_i
  );
endinterface

// File: rtl/ram_sp_be_192x512_arb.sv
// Three-requester (W, R0, R1) arbiter/sequencer for one single-port
// bit-enable RAM. One access per cycle, combinational ack, read data
// returned with a tagged valid RD_LAT cycles after the grant.
module ram_sp_be_192x512_arb #(
  parameter int unsigned ADR_WD  = 8,
  parameter int unsigned DAT_WD  = 512,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned WR_PRIO = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  ram_sp_be_192x512_arb_if.slave        bus
);

  localparam int unsigned N_REQ = 3;

  // Requester index: bit 0 = W, bit 1 = R0, bit 2 = R1
  logic [N_REQ-1:0]  req_c;
  logic [N_REQ-1:0]  gnt_c;
  logic [2:0]        idx_c;

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] id_q, id_d;

  logic [ADR_WD-1:0] ram_adr_c;
  logic [DAT_WD-1:0] ram_wr_ena_c;
  logic [DAT_WD-1:0] ram_wr_dat_c;
  logic              ram_rd_ena_c;

  // Grant selection and pointer advance
  always_comb begin
    req_c    = {bus.r1_req_i, bus.r0_req_i, bus.w_req_i};
    gnt_c    = '0;
    idx_c    = '0;
    rr_ptr_d = rr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (!rst) begin
      if (WR_PRIO != 0) begin
        // W strictly first; readers alternate below it
        if (req_c[0]) begin
          gnt_c = 3'b001;
        end else if (req_c[1] && (!rd_ptr_q || !req_c[2])) begin
          gnt_c = 3'b010;
        end else if (req_c[2]) begin
          gnt_c = 3'b100;
        end
      end else begin
        // Search W/R0/R1 circularly starting at the pointer
        for (int i = 0; i < int'(N_REQ); i++) begin
          idx_c = 3'(rr_ptr_q) + 3'(i);
          if (idx_c > 3'd2) begin
            idx_c = idx_c - 3'd3;
          end
          if ((gnt_c == '0) && req_c[idx_c[1:0]]) begin
            gnt_c[idx_c[1:0]] = 1'b1;
          end
        end
      end
      if (gnt_c[0]) rr_ptr_d = 2'd1;
      if (gnt_c[1]) rr_ptr_d = 2'd2;
      if (gnt_c[2]) rr_ptr_d = 2'd0;
      if (gnt_c[1]) rd_ptr_d = 1'b1;
      if (gnt_c[2]) rd_ptr_d = 1'b0;
    end
  end

  // RAM pin drive for the granted requester; all zero when idle
  always_comb begin
    ram_adr_c    = '0;
    ram_wr_ena_c = '0;
    ram_wr_dat_c = '0;
    ram_rd_ena_c = 1'b0;
    if (gnt_c[0]) begin
      ram_adr_c    = bus.w_adr_i;
      ram_wr_ena_c = bus.w_msk_i;
      ram_wr_dat_c = bus.w_dat_i;
    end else if (gnt_c[1]) begin
      ram_adr_c    = bus.r0_adr_i;
      ram_rd_ena_c = 1'b1;
    end else if (gnt_c[2]) begin
      ram_adr_c    = bus.r1_adr_i;
      ram_rd_ena_c = 1'b1;
    end
  end

  // Read-return pipeline: {valid, id} shifted once per cycle
  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = gnt_c[1] | gnt_c[2];
    id_d[0]  = gnt_c[2];
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  // State registers; reset drops any reads in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      rd_ptr_q <= 1'b0;
      vld_q    <= '0;
      id_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      id_q     <= id_d;
    end
  end

  assign bus.w_ack_o      = gnt_c[0];
  assign bus.r0_ack_o     = gnt_c[1];
  assign bus.r1_ack_o     = gnt_c[2];
  assign bus.ram_adr_o    = ram_adr_c;
  assign bus.ram_wr_ena_o = ram_wr_ena_c;
  assign bus.ram_wr_dat_o = ram_wr_dat_c;
  assign bus.ram_rd_ena_o = ram_rd_ena_c;

  assign bus.r0_vld_o = !rst && vld_q[RD_LAT-1] && !id_q[RD_LAT-1];
  assign bus.r1_vld_o = !rst && vld_q[RD_LAT-1] &&  id_q[RD_LAT-1];
  assign bus.r0_dat_o = rst ? '0 : bus.ram_rd_dat_i;
  assign bus.r1_dat_o = rst ? '0 : bus.ram_rd_dat_i;

endmodule

// File: tb/tb_ram_sp_be_192x512_arb.sv
// Self-checking bench for ram_sp_be_192x512_arb: round-robin main instance
// with a RAM model, a write-priority instance and an RD_LAT=2 instance.
module tb_ram_sp_be_192x512_arb;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 512;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ram_sp_be_192x512_arb_if #(.ADR_WD(AW), .DAT_WD(DW)) bm ();
  ram_sp_be_192x512_arb_if #(.ADR_WD(AW), .DAT_WD(DW)) bp ();
  ram_sp_be_192x512_arb_if #(.ADR_WD(AW), .DAT_WD(DW)) bl ();

  ram_sp_be_192x512_arb #(.ADR_WD(AW), .DAT_WD(DW), .RD_LAT(1), .WR_PRIO(0))
    u_main (.clk(clk), .rst(rst), .bus(bm));
  ram_sp_be_192x512_arb #(.ADR_WD(AW), .DAT_WD(DW), .RD_LAT(1), .WR_PRIO(1))
    u_prio (.clk(clk), .rst(rst), .bus(bp));
  ram_sp_be_192x512_arb #(.ADR_WD(AW), .DAT_WD(DW), .RD_LAT(2), .WR_PRIO(0))
    u_lat2 (.clk(clk), .rst(rst), .bus(bl));

  // RAM macro model behind the main instance (1-cycle read latency)
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (bm.ram_rd_ena_o) rd_q <= mem[bm.ram_adr_o];
    if (|bm.ram_wr_ena_o)
      mem[bm.ram_adr_o] <= (mem[bm.ram_adr_o] & ~bm.ram_wr_ena_o) |
                           (bm.ram_wr_dat_o & bm.ram_wr_ena_o);
  end
  assign bm.ram_rd_dat_i = rd_q;
  assign bp.ram_rd_dat_i = '0;
  assign bl.ram_rd_dat_i = '0;

  // Reference contents, updated from the bench's own stimulus
  logic [DW-1:0] shadow [256];

  typedef struct {
    logic [2:0] req;   // {r1, r0, w}
    logic [2:0] ack;   // expected {r1, r0, w}
  } vec_t;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic shadow_wr(input logic [AW-1:0] a, input logic [DW-1:0] m, input logic [DW-1:0] d);
    shadow[a] = (shadow[a] & ~m) | (d & m);
  endtask

  task automatic idle_all();
    bm.w_req_i = 0; bm.w_adr_i = '0; bm.w_msk_i = '0; bm.w_dat_i = '0;
    bm.r0_req_i = 0; bm.r0_adr_i = '0; bm.r1_req_i = 0; bm.r1_adr_i = '0;
    bp.w_req_i = 0; bp.w_adr_i = '0; bp.w_msk_i = '0; bp.w_dat_i = '0;
    bp.r0_req_i = 0; bp.r0_adr_i = '0; bp.r1_req_i = 0; bp.r1_adr_i = '0;
    bl.w_req_i = 0; bl.w_adr_i = '0; bl.w_msk_i = '0; bl.w_dat_i = '0;
    bl.r0_req_i = 0; bl.r0_adr_i = '0; bl.r1_req_i = 0; bl.r1_adr_i = '0;
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t          tbl [16];
  logic          req_m [3];
  logic [AW-1:0] adr_m [3];
  logic [DW-1:0] msk_m, dat_m;
  logic          pend [3];
  int            ptr_m;
  int            g;
  logic          ev0, ev1;
  logic [DW-1:0] edat;
  logic [DW-1:0] ones128;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; shadow[i] = '0; end
    rd_q = '0;
    idle_all();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Outputs held at zero while reset is asserted, even with requests
    bm.w_req_i = 1; bm.r0_req_i = 1; bm.r1_req_i = 1; bm.w_adr_i = 8'h33;
    #1;
    chk("rst_acks", DW'({bm.r1_ack_o, bm.r0_ack_o, bm.w_ack_o}), '0);
    chk("rst_vld", DW'({bm.r1_vld_o, bm.r0_vld_o}), '0);
    chk("rst_ram_adr", DW'(bm.ram_adr_o), '0);
    chk("rst_rd_ena", DW'(bm.ram_rd_ena_o), '0);
    idle_all();
    @(negedge clk); rst = 1'b0;
    #1;
    chk("idle_acks", DW'({bm.r1_ack_o, bm.r0_ack_o, bm.w_ack_o}), '0);
    chk("idle_vld", DW'({bm.r1_vld_o, bm.r0_vld_o}), '0);
    chk("idle_rd_ena", DW'(bm.ram_rd_ena_o), '0);
    chk("idle_wr_ena", bm.ram_wr_ena_o, '0);
    chk("idle_adr", DW'(bm.ram_adr_o), '0);

    // Round-robin grant table from reset
    tbl[0]  = '{3'b111, 3'b001}; tbl[1]  = '{3'b111, 3'b010}; tbl[2]  = '{3'b111, 3'b100};
    tbl[3]  = '{3'b111, 3'b001}; tbl[4]  = '{3'b111, 3'b010}; tbl[5]  = '{3'b111, 3'b100};
    tbl[6]  = '{3'b111, 3'b001}; tbl[7]  = '{3'b111, 3'b010}; tbl[8]  = '{3'b111, 3'b100};
    tbl[9]  = '{3'b000, 3'b000}; tbl[10] = '{3'b100, 3'b100}; tbl[11] = '{3'b110, 3'b010};
    tbl[12] = '{3'b011, 3'b001}; tbl[13] = '{3'b101, 3'b100}; tbl[14] = '{3'b010, 3'b010};
    tbl[15] = '{3'b001, 3'b001};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bm.w_req_i = tbl[i].req[0]; bm.r0_req_i = tbl[i].req[1]; bm.r1_req_i = tbl[i].req[2];
      bm.w_adr_i = 8'h01; bm.r0_adr_i = 8'h02; bm.r1_adr_i = 8'h03; bm.w_msk_i = '0;
      #1;
      chk($sformatf("tbl_ack[%0d]", i), DW'({bm.r1_ack_o, bm.r0_ack_o, bm.w_ack_o}), DW'(tbl[i].ack));
      chk($sformatf("tbl_wr_ena[%0d]", i), bm.ram_wr_ena_o, '0);
    end
    idle_all();

    // Write 0x12 then read it back through R0 on the next cycle
    @(negedge clk);
    bm.w_req_i = 1; bm.w_adr_i = 8'h12; bm.w_msk_i = '1; bm.w_dat_i = {64{8'hA5}};
    #1;
    chk("wr_ack", DW'(bm.w_ack_o), DW'(1));
    chk("wr_ram_adr", DW'(bm.ram_adr_o), DW'(8'h12));
    chk("wr_ram_ena", bm.ram_wr_ena_o, '1);
    chk("wr_ram_dat", bm.ram_wr_dat_o, {64{8'hA5}});
    shadow_wr(8'h12, '1, {64{8'hA5}});
    @(negedge clk);
    idle_all(); bm.r0_req_i = 1; bm.r0_adr_i = 8'h12;
    #1;
    chk("raw_r0_ack", DW'(bm.r0_ack_o), DW'(1));
    chk("raw_rd_ena", DW'(bm.ram_rd_ena_o), DW'(1));
    chk("raw_wr_ena", bm.ram_wr_ena_o, '0);
    @(negedge clk);
    idle_all();
    #1;
    chk("raw_r0_vld", DW'({bm.r1_vld_o, bm.r0_vld_o}), DW'(2'b01));
    chk("raw_r0_dat", bm.r0_dat_o, {64{8'hA5}});

    // Partial bit-enable write, read back through R1
    ones128 = '0; ones128[127:0] = '1;
    @(negedge clk);
    bm.w_req_i = 1; bm.w_adr_i = 8'h40; bm.w_msk_i = '1; bm.w_dat_i = '0;
    shadow_wr(8'h40, '1, '0);
    @(negedge clk);
    bm.w_msk_i = ones128; bm.w_dat_i = '1;
    shadow_wr(8'h40, ones128, '1);
    @(negedge clk);
    idle_all(); bm.r1_req_i = 1; bm.r1_adr_i = 8'h40;
    #1;
    chk("pm_r1_ack", DW'(bm.r1_ack_o), DW'(1));
    @(negedge clk);
    idle_all();
    #1;
    chk("pm_r1_vld", DW'({bm.r1_vld_o, bm.r0_vld_o}), DW'(2'b10));
    chk("pm_r1_dat", bm.r1_dat_o, ones128);

    // Random traffic against the reference model
    reset_pulse();
    ptr_m = 0; ev0 = 0; ev1 = 0; edat = '0;
    for (int k = 0; k < 3; k++) pend[k] = 0;
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!pend[k]) begin
          req_m[k] = ($urandom_range(0, 1) == 1);
          adr_m[k] = 8'h10 + 8'($urandom_range(0, 3));
          if (k == 0) begin
            msk_m = ($urandom_range(0, 9) == 0) ? '0 : rand_wide();
            dat_m = rand_wide();
          end
        end
      end
      bm.w_req_i = req_m[0]; bm.w_adr_i = adr_m[0]; bm.w_msk_i = msk_m; bm.w_dat_i = dat_m;
      bm.r0_req_i = req_m[1]; bm.r0_adr_i = adr_m[1];
      bm.r1_req_i = req_m[2]; bm.r1_adr_i = adr_m[2];
      g = -1;
      for (int i = 0; i < 3; i++)
        if (g < 0 && req_m[(ptr_m + i) % 3]) g = (ptr_m + i) % 3;
      #1;
      chk("rnd_ack", DW'({bm.r1_ack_o, bm.r0_ack_o, bm.w_ack_o}),
          (g < 0) ? '0 : DW'(3'b001 << g));
      chk("rnd_ram_adr", DW'(bm.ram_adr_o), (g < 0) ? '0 : DW'(adr_m[g]));
      chk("rnd_ram_wr_ena", bm.ram_wr_ena_o, (g == 0) ? msk_m : '0);
      chk("rnd_ram_wr_dat", bm.ram_wr_dat_o, (g == 0) ? dat_m : '0);
      chk("rnd_ram_rd_ena", DW'(bm.ram_rd_ena_o), DW'(g > 0));
      chk("rnd_vld", DW'({bm.r1_vld_o, bm.r0_vld_o}), DW'({ev1, ev0}));
      if (ev0) chk("rnd_r0_dat", bm.r0_dat_o, edat);
      if (ev1) chk("rnd_r1_dat", bm.r1_dat_o, edat);
      ev0 = (g == 1); ev1 = (g == 2);
      if (g == 0) shadow_wr(adr_m[0], msk_m, dat_m);
      if (g > 0) edat = shadow[adr_m[g]];
      if (g >= 0) ptr_m = (g + 1) % 3;
      for (int k = 0; k < 3; k++) pend[k] = req_m[k] && (g != k);
    end
    idle_all();

    // Write-priority instance: W always wins, readers alternate below it
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bp.w_req_i = 1; bp.r1_req_i = 1;
      #1;
      chk($sformatf("prio_w[%0d]", i), DW'({bp.r1_ack_o, bp.r0_ack_o, bp.w_ack_o}), DW'(3'b001));
      @(negedge clk);
    end
    bp.w_req_i = 0;
    #1;
    chk("prio_r1_after_w", DW'({bp.r1_ack_o, bp.r0_ack_o, bp.w_ack_o}), DW'(3'b100));
    @(negedge clk);
    bp.r0_req_i = 1;
    #1;
    chk("prio_r0_turn", DW'({bp.r1_ack_o, bp.r0_ack_o, bp.w_ack_o}), DW'(3'b010));
    @(negedge clk);
    bp.r0_req_i = 0;
    #1;
    chk("prio_r1_turn", DW'({bp.r1_ack_o, bp.r0_ack_o, bp.w_ack_o}), DW'(3'b100));
    @(negedge clk);
    bp.r1_req_i = 0;

    // RD_LAT=2: valid exactly two cycles after the grant
    bl.r0_req_i = 1; bl.r0_adr_i = 8'h05;
    #1;
    chk("lat2_ack", DW'(bl.r0_ack_o), DW'(1));
    @(negedge clk); bl.r0_req_i = 0; #1;
    chk("lat2_vld_c1", DW'(bl.r0_vld_o), '0);
    @(negedge clk); #1;
    chk("lat2_vld_c2", DW'(bl.r0_vld_o), DW'(1));
    @(negedge clk); #1;
    chk("lat2_vld_c3", DW'(bl.r0_vld_o), '0);

    // Reset mid-read drops the return and restores the pointer
    @(negedge clk);
    bl.r0_req_i = 1;
    #1;
    chk("lat2_rst_ack", DW'(bl.r0_ack_o), DW'(1));
    @(negedge clk); bl.r0_req_i = 0;
    #2 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk($sformatf("lat2_rst_vld[%0d]", i), DW'(bl.r0_vld_o), '0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("lat2_post_vld[%0d]", i), DW'({bl.r1_vld_o, bl.r0_vld_o}), '0);
      @(negedge clk);
    end
    bl.w_req_i = 1; bl.r0_req_i = 1; bl.r1_req_i = 1;
    #1;
    chk("lat2_post_ptr", DW'({bl.r1_ack_o, bl.r0_ack_o, bl.w_ack_o}), DW'(3'b001));
    @(negedge clk);
    idle_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
